// File: rtl/dpram_port_arbiter.sv
// Round-robin arbiter sharing both ports of a dual-port RAM among NUM_REQ requesters.
// Define DPRAM_ARB_COLLISION_EN to hold back a port-B grant that would collide with port A.
module dpram_arb_port #(
    parameter int IDW    = 2,
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              gnt,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [IDW-1:0]    id,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_din,
    output logic              ram_we,
    output logic              ram_re,
    output logic              rvld,
    output logic [IDW-1:0]    rid
);
    // Stage 1 tracks the issued command, stage 2 only survives for reads.
    logic [2:1]     vld_pipe;
    logic [IDW-1:0] id_s1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ram_addr <= '0;
            ram_din  <= '0;
            ram_we   <= 1'b0;
            ram_re   <= 1'b0;
            vld_pipe <= '0;
            id_s1    <= '0;
            rid      <= '0;
        end else begin
            ram_we      <= gnt & we;
            ram_re      <= gnt & ~we;
            if (gnt) begin
                ram_addr <= addr;
                if (we) ram_din <= wdata;
                id_s1 <= id;
            end
            vld_pipe[1] <= gnt;
            vld_pipe[2] <= vld_pipe[1] & ram_re;
            rid         <= id_s1;
        end
    end

    assign rvld = vld_pipe[2];
endmodule

module dpram_port_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 8,
    parameter int ADDR_W  = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ-1:0]        req_we,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        gnt,
    output logic [NUM_REQ-1:0]        rvalid,
    output logic [NUM_REQ*DATA_W-1:0] rdata,
    output logic [ADDR_W-1:0]         ram_addr_a,
    output logic [ADDR_W-1:0]         ram_addr_b,
    output logic [DATA_W-1:0]         ram_din_a,
    output logic [DATA_W-1:0]         ram_din_b,
    output logic                      ram_we_a,
    output logic                      ram_we_b,
    output logic                      ram_re_a,
    output logic                      ram_re_b,
    input  logic [DATA_W-1:0]         ram_dout_a,
    input  logic [DATA_W-1:0]         ram_dout_b
);
    localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0][ADDR_W-1:0] addr_v;
    logic [NUM_REQ-1:0][DATA_W-1:0] wdata_v, rdata_v;
    logic [IDW-1:0] rr_ptr, a_idx, b_idx;
    logic           found_a, found_b, b_clash, gnt_a, gnt_b;

    logic [1:0]             p_gnt, p_we, p_re, p_ram_we, p_rvld;
    logic [1:0][IDW-1:0]    p_id, p_rid;
    logic [1:0][ADDR_W-1:0] p_addr, p_ram_addr;
    logic [1:0][DATA_W-1:0] p_wdata, p_ram_din, p_dout;

    assign addr_v  = req_addr;
    assign wdata_v = req_wdata;
    assign rdata   = rdata_v;

    // A: first request at/after rr_ptr; B: next request after A, both circular.
    always_comb begin
        found_a = 1'b0;
        a_idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!found_a && req[rr_ptr + IDW'(k)]) begin
                found_a = 1'b1;
                a_idx   = rr_ptr + IDW'(k);
            end
        end
        found_b = 1'b0;
        b_idx   = '0;
        for (int k = 1; k < NUM_REQ; k++) begin
            if (found_a && !found_b && req[a_idx + IDW'(k)]) begin
                found_b = 1'b1;
                b_idx   = a_idx + IDW'(k);
            end
        end
    end

`ifdef DPRAM_ARB_COLLISION_EN
    assign b_clash = (addr_v[a_idx] == addr_v[b_idx]) && (req_we[a_idx] || req_we[b_idx]);
`else
    assign b_clash = 1'b0;
`endif

    // Gating with rst keeps gnt low for the whole asynchronous reset window.
    assign gnt_a = found_a & rst;
    assign gnt_b = found_b & ~b_clash & rst;

    always_comb begin
        gnt = '0;
        if (gnt_a) gnt[a_idx] = 1'b1;
        if (gnt_b) gnt[b_idx] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)       rr_ptr <= '0;
        else if (gnt_b) rr_ptr <= b_idx + 1'b1;
        else if (gnt_a) rr_ptr <= a_idx + 1'b1;
    end

    assign p_gnt   = {gnt_b, gnt_a};
    assign p_id    = {b_idx, a_idx};
    assign p_we    = {req_we[b_idx], req_we[a_idx]};
    assign p_addr  = {addr_v[b_idx], addr_v[a_idx]};
    assign p_wdata = {wdata_v[b_idx], wdata_v[a_idx]};
    assign p_dout  = {ram_dout_b, ram_dout_a};

    for (genvar p = 0; p < 2; p++) begin : g_port
        dpram_arb_port #(.IDW(IDW), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_port (
            .clk      (clk),
            .rst      (rst),
            .gnt      (p_gnt[p]),
            .we       (p_we[p]),
            .addr     (p_addr[p]),
            .wdata    (p_wdata[p]),
            .id       (p_id[p]),
            .ram_addr (p_ram_addr[p]),
            .ram_din  (p_ram_din[p]),
            .ram_we   (p_ram_we[p]),
            .ram_re   (p_re[p]),
            .rvld     (p_rvld[p]),
            .rid      (p_rid[p])
        );
    end

    assign ram_addr_a = p_ram_addr[0];
    assign ram_addr_b = p_ram_addr[1];
    assign ram_din_a  = p_ram_din[0];
    assign ram_din_b  = p_ram_din[1];
    assign ram_we_a   = p_ram_we[0];
    assign ram_we_b   = p_ram_we[1];
    assign ram_re_a   = p_re[0];
    assign ram_re_b   = p_re[1];

    // Same-cycle returns always belong to distinct requesters, so no merge conflict.
    always_comb begin
        rvalid  = '0;
        rdata_v = '0;
        for (int p = 0; p < 2; p++) begin
            if (p_rvld[p]) begin
                rvalid[p_rid[p]]  = 1'b1;
                rdata_v[p_rid[p]] = p_dout[p];
            end
        end
    end
endmodule

// File: tb/tb_dpram_port_arbiter.sv
// Directed bench for dpram_port_arbiter with a behavioural 16x8 dual-port RAM.
module tb_dpram_port_arbiter;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [3:0]  req = '0, req_we = '0;
    logic [15:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic [3:0]  gnt, rvalid;
    logic [31:0] rdata;
    logic [3:0]  ram_addr_a, ram_addr_b;
    logic [7:0]  ram_din_a, ram_din_b, ram_dout_a, ram_dout_b;
    logic        ram_we_a, ram_we_b, ram_re_a, ram_re_b;
    logic [7:0]  mem [16];
    logic        preload = 1'b0;
    int          n_cmp = 0, n_err = 0;

    dpram_port_arbiter #(.NUM_REQ(4), .DATA_W(8), .ADDR_W(4)) dut (
        .clk(clk), .rst(rst), .req(req), .req_we(req_we), .req_addr(req_addr),
        .req_wdata(req_wdata), .gnt(gnt), .rvalid(rvalid), .rdata(rdata),
        .ram_addr_a(ram_addr_a), .ram_addr_b(ram_addr_b), .ram_din_a(ram_din_a),
        .ram_din_b(ram_din_b), .ram_we_a(ram_we_a), .ram_we_b(ram_we_b),
        .ram_re_a(ram_re_a), .ram_re_b(ram_re_b), .ram_dout_a(ram_dout_a),
        .ram_dout_b(ram_dout_b)
    );

    always #5 clk = ~clk;

    // RAM model: port B write lands last, reads return pre-edge contents.
    always @(posedge clk) begin
        if (preload) for (int i = 0; i < 16; i++) mem[i] <= 8'h10 + 8'(i);
        if (ram_we_a) mem[ram_addr_a] <= ram_din_a;
        if (ram_we_b) mem[ram_addr_b] <= ram_din_b;
        if (ram_re_a) ram_dout_a <= mem[ram_addr_a];
        if (ram_re_b) ram_dout_b <= mem[ram_addr_b];
    end

    task automatic drive(input int i, input logic we, input logic [3:0] a, input logic [7:0] d);
        req[i] = 1'b1;
        req_we[i] = we;
        req_addr[i*4 +: 4] = a;
        req_wdata[i*8 +: 8] = d;
    endtask

    task automatic pulse_reset();
        @(negedge clk); rst = 1'b0;
        @(negedge clk); rst = 1'b1;
    endtask

    task automatic test_reset();
        req = 4'hF;
        #1;
        n_cmp++; if (gnt !== 4'h0) begin n_err++; $display("FAIL reset_gnt got %h want 0", gnt); end
        n_cmp++; if (rvalid !== 4'h0 || rdata !== 32'h0) begin n_err++; $display("FAIL reset_rvalid got %h/%h want 0/0", rvalid, rdata); end
        n_cmp++; if ({ram_addr_a, ram_addr_b, ram_din_a, ram_din_b, ram_we_a, ram_we_b, ram_re_a, ram_re_b} !== 28'h0) begin
            n_err++; $display("FAIL reset_ram got %h want 0", {ram_addr_a, ram_addr_b, ram_din_a, ram_din_b}); end
        req = 4'h0;
        @(negedge clk); rst = 1'b1;
    endtask

    task automatic test_write_read();
        @(negedge clk); drive(0, 1'b1, 4'd3, 8'hA5); #1;
        n_cmp++; if (gnt !== 4'b0001) begin n_err++; $display("FAIL wr_gnt got %b want 0001", gnt); end
        @(negedge clk); req = 4'h0;
        n_cmp++; if ({ram_we_a, ram_re_a, ram_addr_a, ram_din_a} !== {1'b1, 1'b0, 4'd3, 8'hA5}) begin
            n_err++; $display("FAIL wr_cmd got we%b re%b a%h d%h want we1 re0 a3 dA5", ram_we_a, ram_re_a, ram_addr_a, ram_din_a); end
        drive(0, 1'b0, 4'd3, 8'h00); #1;
        n_cmp++; if (gnt !== 4'b0001) begin n_err++; $display("FAIL rd_gnt got %b want 0001", gnt); end
        @(negedge clk); req = 4'h0;
        n_cmp++; if (ram_re_a !== 1'b1 || rvalid !== 4'h0) begin n_err++; $display("FAIL rd_cmd got re%b rv%b want re1 rv0000", ram_re_a, rvalid); end
        @(negedge clk);
        n_cmp++; if (rvalid !== 4'b0001 || rdata !== 32'h0000_00A5) begin n_err++; $display("FAIL rd_ret got %b/%h want 0001/000000a5", rvalid, rdata); end
        @(negedge clk);
        n_cmp++; if (rvalid !== 4'h0) begin n_err++; $display("FAIL rd_pulse got %b want 0000", rvalid); end
    endtask

    task automatic test_rr_order();
        @(negedge clk); rst = 1'b0; preload = 1'b1;
        @(negedge clk); rst = 1'b1; preload = 1'b0;
        for (int i = 0; i < 4; i++) drive(i, 1'b0, 4'(i), 8'h00);
        #1;
        n_cmp++; if (gnt !== 4'b0011) begin n_err++; $display("FAIL rr_c0 got %b want 0011", gnt); end
        @(negedge clk); req[1:0] = 2'b00; #1;
        n_cmp++; if (gnt !== 4'b1100) begin n_err++; $display("FAIL rr_c1 got %b want 1100", gnt); end
        n_cmp++; if ({ram_addr_a, ram_addr_b, ram_re_a, ram_re_b} !== {4'd0, 4'd1, 2'b11}) begin
            n_err++; $display("FAIL rr_cmd got a%h b%h want a0 b1", ram_addr_a, ram_addr_b); end
        @(negedge clk); req = 4'h0;
        n_cmp++; if (rvalid !== 4'b0011 || rdata !== 32'h0000_1110) begin n_err++; $display("FAIL rr_ret0 got %b/%h want 0011/00001110", rvalid, rdata); end
        @(negedge clk);
        n_cmp++; if (rvalid !== 4'b1100 || rdata !== 32'h1312_0000) begin n_err++; $display("FAIL rr_ret1 got %b/%h want 1100/13120000", rvalid, rdata); end
        for (int i = 0; i < 4; i++) drive(i, 1'b0, 4'(i), 8'h00);
        #1;
        n_cmp++; if (gnt !== 4'b0011) begin n_err++; $display("FAIL rr_ptr0 got %b want 0011", gnt); end
        @(negedge clk); req = 4'h0;
        @(negedge clk); @(negedge clk);
    endtask

    task automatic test_wrap();
        drive(2, 1'b0, 4'd2, 8'h00); #1;
        n_cmp++; if (gnt !== 4'b0100) begin n_err++; $display("FAIL wrap_pre got %b want 0100", gnt); end
        @(negedge clk); req = 4'h0;
        drive(3, 1'b0, 4'd2, 8'h00); drive(0, 1'b0, 4'd0, 8'h00); #1;
        n_cmp++; if (gnt !== 4'b1001) begin n_err++; $display("FAIL wrap_gnt got %b want 1001", gnt); end
        @(negedge clk); req = 4'h0;
        drive(0, 1'b0, 4'd8, 8'h00); drive(1, 1'b0, 4'd9, 8'h00); #1;
        n_cmp++; if (ram_addr_a !== 4'd2 || ram_addr_b !== 4'd0) begin n_err++; $display("FAIL wrap_ports got a%h b%h want a2 b0", ram_addr_a, ram_addr_b); end
        n_cmp++; if (gnt !== 4'b0011) begin n_err++; $display("FAIL wrap_next got %b want 0011", gnt); end
        @(negedge clk); req = 4'h0;
        n_cmp++; if (rvalid !== 4'b1001 || rdata !== 32'h1200_0010) begin n_err++; $display("FAIL wrap_ret got %b/%h want 1001/12000010", rvalid, rdata); end
        n_cmp++; if (ram_addr_a !== 4'd9 || ram_addr_b !== 4'd8) begin n_err++; $display("FAIL wrap_ptr1 got a%h b%h want a9 b8", ram_addr_a, ram_addr_b); end
        @(negedge clk);
        n_cmp++; if (rvalid !== 4'b0011 || rdata !== 32'h0000_1918) begin n_err++; $display("FAIL wrap_ret2 got %b/%h want 0011/00001918", rvalid, rdata); end
    endtask

    task automatic test_collision();
        pulse_reset();
`ifdef DPRAM_ARB_COLLISION_EN
        drive(0, 1'b1, 4'd5, 8'h3C); drive(1, 1'b0, 4'd5, 8'h00); #1;
        n_cmp++; if (gnt !== 4'b0001) begin n_err++; $display("FAIL col_gnt0 got %b want 0001", gnt); end
        @(negedge clk); req[0] = 1'b0; #1;
        n_cmp++; if (gnt !== 4'b0010) begin n_err++; $display("FAIL col_gnt1 got %b want 0010", gnt); end
        @(negedge clk); req = 4'h0;
        drive(2, 1'b0, 4'd5, 8'h00); drive(3, 1'b0, 4'd5, 8'h00); #1;
        n_cmp++; if (gnt !== 4'b1100) begin n_err++; $display("FAIL col_rdrd got %b want 1100", gnt); end
        @(negedge clk); req = 4'h0;
        n_cmp++; if (rvalid !== 4'b0010 || rdata !== 32'h0000_3C00) begin n_err++; $display("FAIL col_ret got %b/%h want 0010/00003c00", rvalid, rdata); end
        @(negedge clk);
        n_cmp++; if (rvalid !== 4'b1100 || rdata !== 32'h3C3C_0000) begin n_err++; $display("FAIL col_rdrd_ret got %b/%h want 1100/3c3c0000", rvalid, rdata); end
`else
        drive(0, 1'b1, 4'd7, 8'h11); drive(1, 1'b1, 4'd7, 8'h22); #1;
        n_cmp++; if (gnt !== 4'b0011) begin n_err++; $display("FAIL ww_gnt got %b want 0011", gnt); end
        @(negedge clk); req = 4'h0;
        drive(2, 1'b0, 4'd7, 8'h00); #1;
        n_cmp++; if (gnt !== 4'b0100) begin n_err++; $display("FAIL ww_rd_gnt got %b want 0100", gnt); end
        @(negedge clk); req = 4'h0;
        @(negedge clk);
        n_cmp++; if (rvalid !== 4'b0100 || rdata !== 32'h0022_0000) begin n_err++; $display("FAIL ww_ret got %b/%h want 0100/00220000", rvalid, rdata); end
        drive(0, 1'b1, 4'd7, 8'h55); drive(1, 1'b0, 4'd7, 8'h00); #1;
        n_cmp++; if (gnt !== 4'b0011) begin n_err++; $display("FAIL rw_gnt got %b want 0011", gnt); end
        @(negedge clk); req = 4'h0;
        @(negedge clk);
        n_cmp++; if (rvalid !== 4'b0010 || rdata !== 32'h0000_2200) begin n_err++; $display("FAIL rw_old got %b/%h want 0010/00002200", rvalid, rdata); end
`endif
        @(negedge clk);
    endtask

    task automatic test_reset_inflight();
        drive(0, 1'b0, 4'd0, 8'h00); #1;
        n_cmp++; if (gnt !== 4'b0001) begin n_err++; $display("FAIL rst_rd_gnt got %b want 0001", gnt); end
        @(negedge clk); rst = 1'b0; req = 4'hF; #1;
        n_cmp++; if (gnt !== 4'h0 || rvalid !== 4'h0 || rdata !== 32'h0) begin n_err++; $display("FAIL rst_mid got %b/%b/%h want 0/0/0", gnt, rvalid, rdata); end
        n_cmp++; if ({ram_addr_a, ram_addr_b, ram_din_a, ram_din_b, ram_we_a, ram_we_b, ram_re_a, ram_re_b} !== 28'h0) begin
            n_err++; $display("FAIL rst_mid_ram got re%b%b a%h want all 0", ram_re_a, ram_re_b, ram_addr_a); end
        @(negedge clk);
        n_cmp++; if (rvalid !== 4'h0) begin n_err++; $display("FAIL rst_drop got %b want 0000", rvalid); end
        rst = 1'b1; req = 4'h0;
        drive(0, 1'b0, 4'd4, 8'h00); drive(3, 1'b0, 4'd6, 8'h00); #1;
        n_cmp++; if (gnt !== 4'b1001) begin n_err++; $display("FAIL rst_restart got %b want 1001", gnt); end
        @(negedge clk); req = 4'h0;
        n_cmp++; if (ram_addr_a !== 4'd4 || ram_addr_b !== 4'd6) begin n_err++; $display("FAIL rst_ptr got a%h b%h want a4 b6", ram_addr_a, ram_addr_b); end
        @(negedge clk);
        n_cmp++; if (rvalid !== 4'b1001 || rdata !== 32'h1600_0014) begin n_err++; $display("FAIL rst_ret got %b/%h want 1001/16000014", rvalid, rdata); end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1);
    end

    initial begin
        @(negedge clk);
        test_reset();
        test_write_read();
        test_rr_order();
        test_wrap();
        test_collision();
        test_reset_inflight();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/dpram_port_arbiter.md
# dpram_port_arbiter

Round-robin arbiter that shares the two ports of the 16x8 dual-port RAM among NUM_REQ requesters. Each cycle it grants up to two requests (one per RAM port), registers them onto the RAM port signals, and routes the read data back to the originating requester with a one-cycle rvalid pulse. It sits between the requester clients and the dual-port RAM instance, and is the only driver of the RAM's port inputs.

## Interface
- NUM_REQ, 4, number of requesters (power of two, 2..8)
- DATA_W, 8, RAM data width
- ADDR_W, 4, RAM address width
- clk  input  1  clock, all logic on rising edge
- rst  input  1  reset, asynchronous, active-low
- req  input  NUM_REQ  per-requester request, held until granted
- req_we  input  NUM_REQ  1 = write, 0 = read
- req_addr  input  NUM_REQ*ADDR_W  packed addresses; requester i at [i*ADDR_W +: ADDR_W]
- req_wdata  input  NUM_REQ*DATA_W  packed write data
- gnt  output  NUM_REQ  combinational; request accepted at this clock edge
- rvalid  output  NUM_REQ  one-cycle read-return pulse
- rdata  output  NUM_REQ*DATA_W  packed read data; valid only with rvalid[i]
- ram_addr_a / ram_addr_b  output  ADDR_W  RAM port address
- ram_din_a / ram_din_b  output  DATA_W  RAM write data
- ram_we_a / ram_we_b  output  1  RAM write enable
- ram_re_a / ram_re_b  output  1  RAM read enable
- ram_dout_a / ram_dout_b  input  DATA_W  registered RAM read data

## Operation
- Round-robin pointer rr_ptr (log2 NUM_REQ bits). Port A candidate: first asserted req at or after rr_ptr, circular. Port B candidate: next asserted req after the A candidate, circular.
- gnt is asserted for granted candidates in the same cycle req is seen. Ungranted requesters keep req, addr, data stable.
- On the edge ending a cycle with at least one grant, rr_ptr <= (index of last granted requester + 1) mod NUM_REQ. No grant leaves rr_ptr unchanged.
- Command registers per port: a granted read sets re=1, we=0; a granted write sets we=1, re=0, din=wdata. No grant sets we=re=0. addr/din hold their last values.
- Tag pipeline per port: stage1 {valid, id} loaded with the command. Stage2 is loaded from stage1 when stage1 is a read. rvalid[id] = stage2.valid; rdata[id] = ram_dout of that port.
- Writes return nothing. gnt is the only acknowledgement.
- Both ports may return to different requesters in the same cycle. A single requester is never granted twice in one cycle.

## Timing
- Read: gnt in cycle N. RAM command in cycle N+1. rvalid/rdata in cycle N+2. Fixed latency of 2; back-to-back grants give one return per cycle per port.
- Write: gnt in cycle N. RAM updated at the edge ending N+1. A read granted in N+1 or later returns the new data.
- Reset (rst low, async): gnt=0 regardless of req, rvalid=0, rdata=0, all ram_* outputs 0, rr_ptr=0, tag pipeline cleared. Reads in flight when reset is asserted are dropped and produce no rvalid.
- First cycle after rst deasserts: normal arbitration starting from requester 0.
- rr_ptr wrap-around: pointer at NUM_REQ-1 with requesters NUM_REQ-1 and 0 pending grants A = NUM_REQ-1 and B = 0.

## Configuration
- DPRAM_ARB_COLLISION_EN defined:
  - The B candidate is rejected when its address equals the A grant's address and either request is a write.
  - That requester stays pending and is considered first-after-A on a later cycle.
  - Same-address read/read is allowed on both ports.
- Not defined:
  - No address comparison; both candidates are always granted.
  - Same-cycle write/write to one address leaves the port B data in RAM.
  - Same-cycle read/write to one address returns the old data on the read.

## Test plan
- Requester 0 writes 0xA5 to addr 3, then reads addr 3. Expect: gnt[0] in the request cycle, rvalid[0] 2 cycles after the read grant, rdata[0]=0xA5.
- After reset, all four requesters read addrs 0..3 preloaded with 0x10..0x13. Expect: cycle 0 grants 0(A), 1(B); cycle 1 grants 2(A), 3(B); returns in order with matching data; rr_ptr=0 afterwards.
- rr_ptr=3 with requesters 3 and 0 pending. Expect: 3 on port A, 0 on port B, rr_ptr becomes 1.
- With DPRAM_ARB_COLLISION_EN: requester 0 writes 0x3C to addr 5 while requester 1 reads addr 5. Expect: only gnt[0], gnt[1] one cycle later, rdata[1]=0x3C.
- Without the macro: requesters 0 and 1 write 0x11 and 0x22 to addr 7 in the same cycle. Expect: both granted, a later read of addr 7 returns 0x22.
- Read granted, rst pulsed low the next cycle. Expect: no rvalid, all outputs 0, gnt=0 during reset, arbitration restarts from requester 0.
